// File: rtl/lisnoc_usb_to_noc_vc_pkg.sv
// Shared lisnoc definitions for the USB-to-NoC bridge: flit type encodings,
// header field offsets and the bridge FSM state type.
package lisnoc_usb_to_noc_vc_pkg;

  localparam logic [1:0] FLIT_TYPE_PAYLOAD = 2'b00;
  localparam logic [1:0] FLIT_TYPE_HEADER  = 2'b01;
  localparam logic [1:0] FLIT_TYPE_LAST    = 2'b10;
  localparam logic [1:0] FLIT_TYPE_SINGLE  = 2'b11;

  // Header word layout: length at the bottom, VC directly above it.
  localparam int HDR_LEN_LSB = 0;

  typedef enum logic [1:0] {
    ST_HEADER = 2'b00,
    ST_GEN    = 2'b01,
    ST_DROP   = 2'b10
  } state_e;

  function automatic int vc_width(input int vchannels);
    return (vchannels > 1) ? $clog2(vchannels) : 1;
  endfunction

  function automatic int hdr_vc_lsb(input int ld_max_len);
    return HDR_LEN_LSB + ld_max_len;
  endfunction

endpackage

// File: rtl/lisnoc_usb_flit_reg.sv
// Single-entry NoC output register: holds one flit with its VC and presents a
// one-hot valid; accepts a new flit whenever it is empty or being drained.
module lisnoc_usb_flit_reg #(
  parameter int DATA_WIDTH = 18,
  parameter int VCHANNELS  = 2,
  parameter int VC_WIDTH   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [VC_WIDTH-1:0]   vc_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] out_noc_data,
  output logic [VCHANNELS-1:0]  out_noc_valid,
  input  logic [VCHANNELS-1:0]  out_noc_ready
);

  logic [DATA_WIDTH-1:0] data_q;
  logic [VC_WIDTH-1:0]   vc_q;
  logic                  valid_q;
  logic                  drained_s;

  // Decode the held VC into the per-VC valid lines.
  always_comb begin
    out_noc_valid = {VCHANNELS{1'b0}};
    for (int i = 0; i < VCHANNELS; i++) begin
      out_noc_valid[i] = valid_q && (vc_q == VC_WIDTH'(i));
    end
  end

  assign drained_s    = |(out_noc_valid & out_noc_ready);
  assign ready_o      = !valid_q || drained_s;
  assign out_noc_data = data_q;

  // Load a new flit, or clear the entry once the current one has drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= {DATA_WIDTH{1'b0}};
      vc_q    <= {VC_WIDTH{1'b0}};
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      vc_q    <= vc_i;
      valid_q <= 1'b1;
    end else if (drained_s) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/lisnoc_usb_to_noc_vc.sv
// USB word stream to NoC flit bridge: each header word selects a VC and a
// packet length; following words become typed flits on that VC.
module lisnoc_usb_to_noc_vc
  import lisnoc_usb_to_noc_vc_pkg::*;
#(
  parameter int FLIT_DATA_WIDTH = 16,
  parameter int FLIT_TYPE_WIDTH = 2,
  parameter int VCHANNELS       = 2,
  parameter int LD_MAX_LEN      = 5
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [FLIT_DATA_WIDTH-1:0]           in_usb_data,
  input  logic                                 in_usb_valid,
  output logic                                 in_usb_ready,
  output logic [FLIT_TYPE_WIDTH+FLIT_DATA_WIDTH-1:0] out_noc_data,
  output logic [VCHANNELS-1:0]                 out_noc_valid,
  input  logic [VCHANNELS-1:0]                 out_noc_ready,
  output logic                                 err_vc
);

  localparam int VC_WIDTH   = vc_width(VCHANNELS);
  localparam int VC_LSB     = hdr_vc_lsb(LD_MAX_LEN);
  localparam int FLIT_WIDTH = FLIT_TYPE_WIDTH + FLIT_DATA_WIDTH;
  localparam logic [LD_MAX_LEN-1:0] CNT_ONE = LD_MAX_LEN'(1);

  state_e                   state_q;
  logic [LD_MAX_LEN-1:0]    len_q;
  logic [LD_MAX_LEN-1:0]    cnt_q;
  logic [VC_WIDTH-1:0]      vc_q;
  logic                     err_vc_q;

  logic [LD_MAX_LEN-1:0]    hdr_len_s;
  logic [VC_WIDTH-1:0]      hdr_vc_s;
  logic [(1<<VC_WIDTH)-1:0] vc_ok_map_s;
  logic                     hdr_vc_ok_s;
  logic                     reg_ready_s;
  logic                     usb_acc_s;
  logic                     load_s;
  logic [1:0]               flit_type_s;

  assign hdr_len_s = in_usb_data[HDR_LEN_LSB +: LD_MAX_LEN];
  assign hdr_vc_s  = in_usb_data[VC_LSB +: VC_WIDTH];

  // Which encodable VC numbers name a channel that actually exists.
  always_comb begin
    for (int i = 0; i < (1 << VC_WIDTH); i++) begin
      vc_ok_map_s[i] = (i < VCHANNELS);
    end
  end

  assign hdr_vc_ok_s = vc_ok_map_s[hdr_vc_s];
  assign usb_acc_s   = in_usb_valid && in_usb_ready;
  assign load_s      = (state_q == ST_GEN) && usb_acc_s;
  assign err_vc      = err_vc_q;

  // USB backpressure only applies while generating flits.
  always_comb begin
    case (state_q)
      ST_HEADER: in_usb_ready = 1'b1;
      ST_DROP:   in_usb_ready = 1'b1;
      ST_GEN:    in_usb_ready = reg_ready_s;
      default:   in_usb_ready = 1'b0;
    endcase
  end

  // Flit type from the position of the word within its packet.
  always_comb begin
    if ((cnt_q == CNT_ONE) && (len_q == CNT_ONE)) begin
      flit_type_s = FLIT_TYPE_SINGLE;
    end else if (cnt_q == CNT_ONE) begin
      flit_type_s = FLIT_TYPE_HEADER;
    end else if (cnt_q == len_q) begin
      flit_type_s = FLIT_TYPE_LAST;
    end else begin
      flit_type_s = FLIT_TYPE_PAYLOAD;
    end
  end

  // Packet framing FSM: header decode, flit generation, discard of bad packets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_HEADER;
      cnt_q    <= CNT_ONE;
      len_q    <= {LD_MAX_LEN{1'b0}};
      vc_q     <= {VC_WIDTH{1'b0}};
      err_vc_q <= 1'b0;
    end else begin
      err_vc_q <= 1'b0;
      case (state_q)
        ST_HEADER: begin
          // Zero-length headers are dummies and leave the FSM waiting.
          if (usb_acc_s && (hdr_len_s != {LD_MAX_LEN{1'b0}})) begin
            len_q <= hdr_len_s;
            cnt_q <= CNT_ONE;
            if (hdr_vc_ok_s) begin
              vc_q    <= hdr_vc_s;
              state_q <= ST_GEN;
            end else begin
              err_vc_q <= 1'b1;
              state_q  <= ST_DROP;
            end
          end
        end
        ST_GEN, ST_DROP: begin
          if (usb_acc_s) begin
            if (cnt_q == len_q) begin
              cnt_q   <= CNT_ONE;
              state_q <= ST_HEADER;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end
        default: begin
          state_q <= ST_HEADER;
          cnt_q   <= CNT_ONE;
        end
      endcase
    end
  end

  lisnoc_usb_flit_reg #(
    .DATA_WIDTH (FLIT_WIDTH),
    .VCHANNELS  (VCHANNELS),
    .VC_WIDTH   (VC_WIDTH)
  ) u_flit_reg (
    .clk           (clk),
    .rst           (rst),
    .load_i        (load_s),
    .data_i        ({FLIT_TYPE_WIDTH'(flit_type_s), in_usb_data}),
    .vc_i          (vc_q),
    .ready_o       (reg_ready_s),
    .out_noc_data  (out_noc_data),
    .out_noc_valid (out_noc_valid),
    .out_noc_ready (out_noc_ready)
  );

endmodule

// File: tb/tb_lisnoc_usb_to_noc_vc.sv
// Bench for the USB-to-NoC bridge with three VCs, so that VC 3 is an invalid
// channel; a packet-level scoreboard predicts every flit and error pulse.
module tb_lisnoc_usb_to_noc_vc;

  localparam int VCH = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_usb_data;
  logic        in_usb_valid;
  logic        in_usb_ready;
  logic [17:0] out_noc_data;
  logic [2:0]  out_noc_valid;
  logic [2:0]  out_noc_ready;
  logic        err_vc;

  lisnoc_usb_to_noc_vc #(
    .FLIT_DATA_WIDTH (16),
    .FLIT_TYPE_WIDTH (2),
    .VCHANNELS       (VCH),
    .LD_MAX_LEN      (5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_usb_data   (in_usb_data),
    .in_usb_valid  (in_usb_valid),
    .in_usb_ready  (in_usb_ready),
    .out_noc_data  (out_noc_data),
    .out_noc_valid (out_noc_valid),
    .out_noc_ready (out_noc_ready),
    .err_vc        (err_vc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  vc_oh;
    logic [17:0] data;
  } flit_t;

  typedef struct {
    logic [15:0] hdr;
    int          n_data;
    int          exp_flits;
    int          exp_err;
  } vec_t;

  int    n_pass = 0;
  int    n_total = 0;
  flit_t exp_q[$];

  // Reference model: a word-stream parser (words left in packet, position).
  int    m_rem = 0, m_len = 0, m_idx = 0, m_vc = 0;
  bit    m_drop = 1'b0, err_pend = 1'b0;
  bit    prev_stall = 1'b0, last_acc = 1'b0;
  bit    rdy_rand = 1'b0;
  logic [2:0]  rdy_force = 3'b111;
  logic [2:0]  prev_valid;
  logic [17:0] prev_data;
  int    obs_flits = 0, obs_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [1:0] exp_type(input int idx, input int len);
    if (len == 1) return 2'b11;
    if (idx == 1) return 2'b01;
    if (idx == len) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_word(input logic [15:0] w);
    flit_t f;
    if (m_rem == 0) begin
      if (int'(w[4:0]) != 0) begin
        m_len    = int'(w[4:0]);
        m_vc     = int'(w[6:5]);
        m_rem    = m_len;
        m_idx    = 1;
        m_drop   = (m_vc >= VCH);
        err_pend = m_drop;
      end
    end else begin
      m_rem--;
      if (!m_drop) begin
        f.vc_oh = 3'(1 << m_vc);
        f.data  = {exp_type(m_idx, m_len), w};
        exp_q.push_back(f);
        m_idx++;
      end
    end
  endtask

  task automatic monitor();
    flit_t f;
    if (rst) begin
      exp_q.delete();
      m_rem = 0; m_drop = 1'b0; err_pend = 1'b0;
      prev_stall = 1'b0; last_acc = 1'b0;
      return;
    end
    check("err_vc_pulse", 32'(err_vc), 32'(err_pend));
    if (err_vc) obs_err++;
    err_pend = 1'b0;
    check("valid_onehot", 32'($countones(out_noc_valid) <= 1), 32'd1);
    if (prev_stall) begin
      check("stall_data_stable", 32'(out_noc_data), 32'(prev_data));
      check("stall_valid_stable", 32'(out_noc_valid), 32'(prev_valid));
    end
    if (|(out_noc_valid & out_noc_ready)) begin
      obs_flits++;
      if (exp_q.size() == 0) begin
        check("unexpected_flit", 32'({out_noc_valid, out_noc_data}), 32'd0);
      end else begin
        f = exp_q.pop_front();
        check("flit", 32'({out_noc_valid, out_noc_data}), 32'({f.vc_oh, f.data}));
      end
    end
    if (m_rem == 0 || m_drop)
      check("usb_ready_idle", 32'(in_usb_ready), 32'd1);
    else
      check("usb_ready_gen", 32'(in_usb_ready),
            32'(!(|out_noc_valid) || (|(out_noc_valid & out_noc_ready))));
    prev_stall = (|out_noc_valid) && !(|(out_noc_valid & out_noc_ready));
    prev_data  = out_noc_data;
    prev_valid = out_noc_valid;
    last_acc   = in_usb_valid && in_usb_ready;
    if (last_acc) model_word(in_usb_data);
  endtask

  // One clock: observe at the falling edge, update NoC ready after the rising edge.
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    out_noc_ready = rdy_rand ? 3'($urandom_range(0, 7)) : rdy_force;
  endtask

  task automatic send_word(input logic [15:0] w, input int gap, output int tries);
    in_usb_valid = 1'b0;
    for (int g = 0; g < gap; g++) step();
    in_usb_data  = w;
    in_usb_valid = 1'b1;
    tries = 0;
    do begin
      step();
      tries++;
    end while (!last_acc && tries < 100);
    in_usb_valid = 1'b0;
    if (!last_acc) check("usb_accept_timeout", 32'(tries), 32'd0);
  endtask

  task automatic drain();
    int n;
    rdy_rand  = 1'b0;
    rdy_force = 3'b111;
    in_usb_valid = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || out_noc_valid != 3'b000) && n < 64) begin
      step();
      n++;
    end
    step();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  vec_t vecs[11];

  initial begin
    int tries, tot, f0, e0, len;
    logic [15:0] w;

    vecs[0]  = '{16'h0000, 0, 0, 0};
    vecs[1]  = '{16'h0000, 0, 0, 0};
    vecs[2]  = '{16'h0000, 0, 0, 0};
    vecs[3]  = '{16'h0000, 0, 0, 0};
    vecs[4]  = '{16'h0002, 2, 2, 0};
    vecs[5]  = '{16'h0062, 2, 0, 1};
    vecs[6]  = '{16'h0041, 1, 1, 0};
    vecs[7]  = '{16'h0070, 16, 0, 1};
    vecs[8]  = '{16'h0025, 5, 5, 0};
    vecs[9]  = '{16'hFF23, 3, 3, 0};
    vecs[10] = '{16'h0060, 0, 0, 0};

    rst = 1'b1;
    in_usb_valid = 1'b0;
    in_usb_data = 16'h0000;
    out_noc_ready = 3'b000;
    repeat (3) step();
    rst = 1'b0;
    #1;
    check("rst_valid", 32'(out_noc_valid), 32'd0);
    check("rst_data", 32'(out_noc_data), 32'd0);
    check("rst_err", 32'(err_vc), 32'd0);
    check("rst_usb_ready", 32'(in_usb_ready), 32'd1);

    // Single-flit packet on VC0, visible one cycle after acceptance.
    send_word(16'h0001, 0, tries);
    send_word(16'hABCD, 0, tries);
    check("single_valid", 32'(out_noc_valid), 32'h1);
    check("single_data", 32'(out_noc_data), 32'h3ABCD);
    drain();

    // Three-flit packet on VC1 with a two-cycle stall after the first flit.
    send_word(16'h0023, 0, tries);
    send_word(16'h000A, 0, tries);
    rdy_force = 3'b000;
    out_noc_ready = 3'b000;
    in_usb_data = 16'h000B;
    in_usb_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("stall_usb_ready", 32'(in_usb_ready), 32'd0);
      check("stall_valid", 32'(out_noc_valid), 32'h2);
      check("stall_data", 32'(out_noc_data), 32'h1000A);
      step();
    end
    rdy_force = 3'b111;
    out_noc_ready = 3'b111;
    send_word(16'h000B, 0, tries);
    send_word(16'h000C, 0, tries);
    check("vc1_last_valid", 32'(out_noc_valid), 32'h2);
    check("vc1_last_data", 32'(out_noc_data), 32'h2000C);
    drain();

    // Table of header cases under random NoC backpressure and USB gaps.
    foreach (vecs[i]) begin
      f0 = obs_flits;
      e0 = obs_err;
      rdy_rand = 1'b1;
      send_word(vecs[i].hdr, $urandom_range(0, 2), tries);
      for (int d = 0; d < vecs[i].n_data; d++)
        send_word(16'($urandom), $urandom_range(0, 2), tries);
      drain();
      check($sformatf("vec%0d_flits", i), 32'(obs_flits - f0), 32'(vecs[i].exp_flits));
      check($sformatf("vec%0d_err", i), 32'(obs_err - e0), 32'(vecs[i].exp_err));
    end

    // Reset after the second flit of a four-flit packet.
    send_word(16'h0004, 0, tries);
    send_word(16'h1111, 0, tries);
    send_word(16'h2222, 0, tries);
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(out_noc_valid), 32'd0);
    step();
    step();
    rst = 1'b0;
    send_word(16'h0001, 0, tries);
    send_word(16'h1234, 0, tries);
    check("postrst_valid", 32'(out_noc_valid), 32'h1);
    check("postrst_data", 32'(out_noc_data), 32'h31234);
    drain();

    // Maximum-length packet streamed at one flit per cycle.
    f0 = obs_flits;
    send_word(16'h001F, 0, tries);
    tot = 0;
    for (int d = 0; d < 31; d++) begin
      send_word(16'($urandom), 0, tries);
      tot += tries;
    end
    check("maxlen_last_type", 32'(out_noc_data[17:16]), 32'h2);
    drain();
    check("maxlen_cycles", 32'(tot), 32'd31);
    check("maxlen_flits", 32'(obs_flits - f0), 32'd31);

    // Random packets, including dummies and invalid-VC drops.
    rdy_rand = 1'b1;
    for (int p = 0; p < 25; p++) begin
      len = $urandom_range(0, 6);
      w = 16'($urandom);
      w[4:0] = 5'(len);
      send_word(w, $urandom_range(0, 1), tries);
      rdy_rand = 1'b1;
      for (int d = 0; d < len; d++) begin
        send_word(16'($urandom), $urandom_range(0, 1), tries);
      end
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
